// File: rtl/data_inst_mem_responder_if.sv
// Fetch and load/store bus between the RV64I core and its unified memory.
// The core drives the master side; the memory responder is the slave.
interface data_inst_mem_responder_if;
    logic [63:0] pc_i;
    logic [63:0] addr_i;
    logic        en_i;
    logic        enwr_i;
    logic [63:0] data_i;
    logic [2:0]  wid_i;
    logic [63:0] data_o;
    logic [31:0] inst_o;
    logic        illegal_access_o;
    logic        unalign_access_o;

    modport master (
        output pc_i, addr_i, en_i, enwr_i, data_i, wid_i,
        input  data_o, inst_o, illegal_access_o, unalign_access_o
    );

    modport slave (
        input  pc_i, addr_i, en_i, enwr_i, data_i, wid_i,
        output data_o, inst_o, illegal_access_o, unalign_access_o
    );
endinterface

// File: rtl/data_inst_mem_responder.sv
// Unified 64-bit synchronous RAM with one fetch port and one load/store port.
// Reads are read-first and registered; sub-word stores merge via byte lanes.
module data_inst_mem_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned DEPTH     = 65536,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    data_inst_mem_responder_if.slave bus
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = BASE_ADDR + 64'(DEPTH) * 64'd8;

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_data;
    logic [31:0] r_inst;
    logic        r_illegal;
    logic        r_unalign;

    logic [AW-1:0] w_pc_idx;
    logic [AW-1:0] w_addr_idx;
    logic          w_pc_in;
    logic          w_addr_in;
    logic          w_fetch_fault;
    logic          w_misalign;
    logic          w_fault;
    logic          w_store;
    logic [7:0]    w_mask;
    logic [7:0]    w_lanes;
    logic [63:0]   w_wdata;
    logic [63:0]   w_pc_word;
    logic [63:0]   w_addr_word;

    // 64-bit bounds compare: addresses below BASE must not wrap into range
    assign w_pc_in    = (bus.pc_i >= BASE_ADDR) && (bus.pc_i < LIMIT);
    assign w_addr_in  = (bus.addr_i >= BASE_ADDR) && (bus.addr_i < LIMIT);
    assign w_pc_idx   = AW'((bus.pc_i - BASE_ADDR) >> 3);
    assign w_addr_idx = AW'((bus.addr_i - BASE_ADDR) >> 3);

    assign w_fetch_fault = !w_pc_in || (bus.pc_i[1:0] != 2'b00);

    always_comb begin
        w_misalign = 1'b0;
        w_mask     = 8'h00;
        unique case (bus.wid_i[1:0])
            2'b00: begin
                w_misalign = 1'b0;
                w_mask     = 8'h01;
            end
            2'b01: begin
                w_misalign = bus.addr_i[0];
                w_mask     = 8'h03;
            end
            2'b10: begin
                w_misalign = |bus.addr_i[1:0];
                w_mask     = 8'h0F;
            end
            default: begin
                w_misalign = |bus.addr_i[2:0];
                w_mask     = 8'hFF;
            end
        endcase
    end

    assign w_fault = !w_addr_in || w_misalign || (&bus.wid_i);
    assign w_store = rst_ni && bus.en_i && !bus.enwr_i && !w_fault;

    // Aligned accesses never shift lanes past byte 7
    assign w_lanes = w_mask << bus.addr_i[2:0];
    assign w_wdata = bus.data_i << {bus.addr_i[2:0], 3'b000};

    assign w_pc_word   = r_mem[w_pc_idx];
    assign w_addr_word = r_mem[w_addr_idx];

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            for (int k = 0; k < 8; k++) begin
                if (w_lanes[k]) begin
                    r_mem[w_addr_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_data    <= 64'd0;
            r_inst    <= NOP_INST;
            r_illegal <= 1'b0;
            r_unalign <= 1'b0;
        end else begin
            r_illegal <= w_fetch_fault;
            if (w_fetch_fault) begin
                r_inst <= NOP_INST;
            end else if (bus.pc_i[2]) begin
                r_inst <= w_pc_word[63:32];
            end else begin
                r_inst <= w_pc_word[31:0];
            end
            r_unalign <= bus.en_i && w_fault;
            // Stores and faulting loads return zero; idle cycles hold
            if (bus.en_i) begin
                if (bus.enwr_i && !w_fault) begin
                    r_data <= w_addr_word;
                end else begin
                    r_data <= 64'd0;
                end
            end
        end
    end

    assign bus.data_o           = r_data;
    assign bus.inst_o           = r_inst;
    assign bus.illegal_access_o = r_illegal;
    assign bus.unalign_access_o = r_unalign;

endmodule

// File: tb/tb_data_inst_mem_responder.sv
// Randomised scoreboard bench for the unified fetch/data memory responder.
// A byte-addressed reference model predicts each registered response.
module tb_data_inst_mem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [63:0] data;
        logic [31:0] inst;
        logic        ill;
        logic        una;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [7:0]  mb [DEPTH*8];
    logic [63:0] m_data = 64'd0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    data_inst_mem_responder_if bus ();

    data_inst_mem_responder #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH),
        .INIT_FILE(""),
        .NOP_INST (NOP)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH * 8));
    endfunction

    function automatic logic [63:0] rd(input logic [63:0] a, input int n);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < n; i++) begin
            r = r | (64'(mb[int'(a - BASE) + i]) << (8 * i));
        end
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input bit ld,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [2:0] w, input logic [63:0] pc);
        exp_t e;
        int   sz;
        bit   f;
        @(negedge clk);
        rst_n      = rst;
        bus.en_i   = en;
        bus.enwr_i = ld;
        bus.addr_i = a;
        bus.data_i = d;
        bus.wid_i  = w;
        bus.pc_i   = pc;
        if (!rst) begin
            m_data = 64'd0;
            e.data = 64'd0;
            e.inst = NOP;
            e.ill  = 1'b0;
            e.una  = 1'b0;
        end else begin
            e.ill  = !in_rng(pc) || (pc % 4 != 0);
            e.inst = e.ill ? NOP : 32'(rd(pc, 4));
            sz     = 1 << w[1:0];
            f      = !in_rng(a) || (w == 3'd7) || (a % sz != 0);
            e.una  = en && f;
            if (en && ld) begin
                m_data = f ? 64'd0 : rd(a - (a % 8), 8);
            end else if (en) begin
                m_data = 64'd0;
                if (!f) begin
                    for (int j = 0; j < sz; j++) begin
                        mb[int'(a - BASE) + j] = d[8*j +: 8];
                    end
                end
            end
            e.data = m_data;
        end
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("data_o", bus.data_o, mon_e.data);
            chk("inst_o", 64'(bus.inst_o), 64'(mon_e.inst));
            chk("illegal_access_o", 64'(bus.illegal_access_o), 64'(mon_e.ill));
            chk("unalign_access_o", 64'(bus.unalign_access_o), 64'(mon_e.una));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] pc;
        bus.en_i   = 1'b0;
        bus.enwr_i = 1'b0;
        bus.addr_i = 64'd0;
        bus.data_i = 64'd0;
        bus.wid_i  = 3'd0;
        bus.pc_i   = 64'd0;

        repeat (2) cyc(0, 0, 0, 0, 0, 3'd3, BASE);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 1, 0, BASE + 64'(8 * i), {$urandom, $urandom}, 3'd3, 64'd0);
        end

        // reset blocks a concurrent store
        cyc(1, 1, 0, BASE, 64'h0123_4567_89AB_CDEF, 3'd3, BASE);
        cyc(0, 1, 0, BASE, 64'hDEAD, 3'd3, BASE);
        cyc(0, 1, 0, BASE, 64'hDEAD, 3'd3, BASE + 4);
        cyc(1, 1, 1, BASE, 0, 3'd3, BASE);

        cyc(1, 1, 0, BASE + 8, 64'h1122_3344_5566_7788, 3'd3, BASE);
        cyc(1, 1, 0, BASE + 'hB, 64'hAA, 3'd0, BASE);
        cyc(1, 1, 1, BASE + 8, 0, 3'd3, BASE);

        cyc(1, 1, 0, BASE, 64'h0050_0093_00A0_0113, 3'd3, BASE);
        cyc(1, 0, 0, 0, 0, 3'd0, BASE + 4);
        cyc(1, 0, 0, 0, 0, 3'd0, BASE + 2);

        cyc(1, 1, 0, BASE + 'h12, 64'h5555_5555, 3'd2, BASE);
        cyc(1, 1, 1, BASE + 'h10, 0, 3'd3, BASE);
        cyc(1, 1, 1, BASE - 8, 0, 3'd3, BASE);

        cyc(1, 1, 0, BASE + 'h20, 64'hFFFF, 3'd3, BASE + 'h20);
        cyc(1, 0, 0, 0, 0, 3'd0, BASE + 'h20);

        cyc(1, 1, 1, BASE + 8, 0, 3'd3, BASE);
        repeat (3) cyc(1, 0, 1, BASE - 8, 0, 3'd7, BASE + 4);
        cyc(1, 1, 1, BASE + 64'(8 * (DEPTH - 1)), 0, 3'd3, BASE);
        cyc(1, 1, 1, BASE + 64'(8 * DEPTH), 0, 3'd3, BASE + 64'(8 * DEPTH - 4));
        cyc(1, 1, 1, BASE + 'h10, 0, 3'd7, BASE + 64'(8 * DEPTH));
        cyc(1, 1, 1, BASE + 'h13, 0, 3'd4, BASE + 1);
        cyc(1, 1, 1, BASE + 'h13, 0, 3'd5, BASE + 8);
        cyc(1, 1, 0, BASE + 'h1E, 64'hBEEF, 3'd1, BASE + 'h18);
        cyc(1, 1, 1, BASE + 'h18, 0, 3'd3, BASE + 'h1C);

        for (int n = 0; n < 600; n++) begin
            a  = BASE - 64'd16 + 64'($urandom_range(0, DEPTH * 8 + 32));
            pc = BASE - 64'd8 + 64'($urandom_range(0, DEPTH * 8 + 16));
            if ($urandom_range(0, 1) == 0) a = a & ~64'd7;
            if ($urandom_range(0, 3) != 0) pc = pc & ~64'd3;
            cyc(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1, a, {$urandom, $urandom},
                3'($urandom_range(0, 7)), pc);
        end

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
